// File: rtl/decodificador_acoes.sv
// Step-code decoder for the toy-dog sequencer. It samples the ripple counter's
// step code, filters out ripple glitches, drives the actuator pattern for that
// step for ACT_CYC cycles, then pulses adv to clock the counter to the next step.
module decodificador_acoes #(
  parameter int STABLE_CYC = 4,
  parameter int ACT_CYC    = 50000,
  parameter int WAIT_MAX   = 1000,
  parameter int TONE_DIV   = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] step,
  output logic       adv,
  output logic       eyes_led,
  output logic       tail_motor,
  output logic       legs_motor,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] cur_step,
  output logic       err
);

  localparam logic [7:0]  STAB_T    = 8'(STABLE_CYC);
  localparam logic [19:0] ACT_LAST  = 20'(ACT_CYC - 1);
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);
  localparam logic [15:0] TONE_LAST = 16'(TONE_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  sync1, sync2;
  logic [7:0]  stab_cnt;
  logic [19:0] act_cnt;
  logic [15:0] wait_cnt;
  logic [15:0] tone_cnt;
  logic        tone_ph;
  logic        stable, accept, timeout, run_on;

  // stab_cnt is the number of consecutive identical samples now held in sync2
  assign stable = (stab_cnt >= STAB_T);
  assign run_on = en && (state == RUN);
  assign busy   = (state != IDLE);

  // Two-flop synchronizer plus stability counter; the counter restarts at 1
  // whenever the sample entering sync2 differs from the one it replaces.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stab_cnt <= '0;
    end else begin
      sync1 <= step;
      sync2 <= sync1;
      if (sync1 != sync2)      stab_cnt <= 8'd1;
      else if (stab_cnt != '1) stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; en low overrides everything and returns to IDLE
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    timeout  = 1'b0;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:   state_nx = SETTLE;
        SETTLE: if (stable) begin
                  accept = 1'b1;
                  // codes 6/7 only flag err; stay here until a legal code settles
                  if (sync2 <= 3'd5) state_nx = RUN;
                end
        RUN:    if (act_cnt == ACT_LAST) state_nx = DONE;
        DONE:   if (sync2 != cur_step)          state_nx = SETTLE;
                else if (wait_cnt == WAIT_LAST) timeout  = 1'b1;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Step latch, sticky error and action/wait timers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_step <= '0;
      err      <= 1'b0;
      act_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (accept) cur_step <= sync2;
      if (!en)                                  err <= 1'b0;
      else if ((accept && sync2[2:1] == 2'b11) || timeout) err <= 1'b1;
      act_cnt <= (state == RUN) ? act_cnt + 20'd1 : '0;
      // wait_cnt == 0 marks the cycle that issues adv, both on DONE entry and
      // after each timeout
      if (state == DONE && state_nx == DONE) wait_cnt <= timeout ? '0 : wait_cnt + 16'd1;
      else                                   wait_cnt <= '0;
    end
  end

  // Bark tone phase generator, restarted low on every RUN entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      tone_ph  <= 1'b0;
    end else if (state == RUN) begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        tone_ph  <= ~tone_ph;
      end else begin
        tone_cnt <= tone_cnt + 16'd1;
      end
    end else begin
      tone_cnt <= '0;
      tone_ph  <= 1'b0;
    end
  end

  // Registered actuator drives and advance pulse. adv comes from DONE, so it
  // always lands one cycle after the actuators drop; the !adv term keeps it
  // from repeating even when WAIT_MAX is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eyes_led   <= 1'b0;
      tail_motor <= 1'b0;
      legs_motor <= 1'b0;
      buzzer     <= 1'b0;
      adv        <= 1'b0;
    end else begin
      eyes_led   <= run_on && (cur_step == 3'd0 || cur_step == 3'd4);
      tail_motor <= run_on && (cur_step == 3'd1 || cur_step == 3'd4);
      legs_motor <= run_on && (cur_step == 3'd3);
      buzzer     <= run_on && (cur_step == 3'd2) && tone_ph;
      adv        <= en && (state == DONE) && (wait_cnt == '0) && !adv;
    end
  end

endmodule

// File: tb/tb_decodificador_acoes.sv
// Bench for decodificador_acoes: per-step table, hand-written corner sequences,
// and a randomized closed loop driven by a ripple-counter model clocked by adv.
module tb_decodificador_acoes;
  localparam int SC = 2, AC = 8, WM = 16, TD = 2;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [2:0] step = 3'd0;
  logic       adv, eyes_led, tail_motor, legs_motor, buzzer, busy, err;
  logic [2:0] cur_step;

  decodificador_acoes #(.STABLE_CYC(SC), .ACT_CYC(AC), .WAIT_MAX(WM), .TONE_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .step(step), .adv(adv),
    .eyes_led(eyes_led), .tail_motor(tail_motor), .legs_motor(legs_motor),
    .buzzer(buzzer), .busy(busy), .cur_step(cur_step), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] code;
    int eyes, tail, legs, buzz;
  } vec_t;

  int nvec = 0, nerr = 0;
  int c_eyes, c_tail, c_legs, c_buzz, n_adv, cyc;
  logic adv_q = 1'b0;
  logic [2:0] pend[$];

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic clr_cnt();
    c_eyes = 0; c_tail = 0; c_legs = 0; c_buzz = 0; n_adv = 0;
  endtask

  // advance one clock, sample #1 later, accumulate and check pulse invariants
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    c_eyes += int'(eyes_led); c_tail += int'(tail_motor);
    c_legs += int'(legs_motor); c_buzz += int'(buzzer); n_adv += int'(adv);
    chk("adv_back_to_back", int'(adv && adv_q), 0);
    chk("adv_with_actuator", int'(adv && (eyes_led || tail_motor || legs_motor || buzzer)), 0);
    adv_q = adv;
  endtask

  task automatic do_reset(input logic [2:0] s, input logic e);
    rst_n = 1'b0; en = e; step = s;
    @(posedge clk); #1;
    adv_q = 1'b0; clr_cnt();
    rst_n = 1'b1;
  endtask

  task automatic wait_adv(input int target, input int bound, input string nm);
    for (int k = 0; k < bound && n_adv < target; k++) tick();
    chk(nm, n_adv, target);
  endtask

  // expected activity per step code, straight from the action table
  function automatic int exp_cnt(input int code, input int which);
    case (which)
      0: return (code == 0 || code == 4) ? AC : 0;   // eyes
      1: return (code == 1 || code == 4) ? AC : 0;   // tail
      2: return (code == 3) ? AC : 0;                // legs
      default: return (code == 2) ? (AC / (2 * TD)) * TD : 0;  // buzzer high cycles
    endcase
  endfunction

  // counter model: after adv, random delay then optional ripple transients
  task automatic counter_advance(input int from);
    logic [2:0] v;
    logic old;
    int d = $urandom_range(0, 3);
    repeat (d) pend.push_back(3'(from));
    if ($urandom_range(0, 1) == 1) begin
      v = 3'(from);
      for (int b = 0; b < 3; b++) begin
        old = v[b];
        v[b] = ~old;
        if (!old) break;
        pend.push_back(v);
      end
      if (v == 3'd6) pend.push_back(v);
    end
    pend.push_back(3'((from + 1) % 6));
  endtask

  initial begin
    vec_t tbl[6];
    int t1, t2, terr, done, exp_code;
    tbl[0] = '{3'd0, AC, 0, 0, 0};
    tbl[1] = '{3'd1, 0, AC, 0, 0};
    tbl[2] = '{3'd2, 0, 0, 0, 4};
    tbl[3] = '{3'd3, 0, 0, AC, 0};
    tbl[4] = '{3'd4, AC, AC, 0, 0};
    tbl[5] = '{3'd5, 0, 0, 0, 0};
    cyc = 0; clr_cnt();

    // reset / idle and latency: step 3 -> legs at 2 + SC + 1 cycles
    rst_n = 1'b0; en = 1'b1; step = 3'd3;
    tick(); tick();
    chk("reset_outputs", int'({adv, eyes_led, tail_motor, legs_motor, buzzer, busy, cur_step, err}), 0);
    rst_n = 1'b1; clr_cnt();
    repeat (2 + SC) tick();
    chk("latency_before", int'(legs_motor), 0);
    tick();
    chk("latency_legs_on", int'(legs_motor), 1);
    wait_adv(1, 40, "first_adv");
    chk("first_legs_len", c_legs, AC);
    chk("first_cur_step", int'(cur_step), 3);
    chk("first_err", int'(err), 0);

    // table of every legal code from reset
    for (int i = 0; i < 6; i++) begin
      do_reset(tbl[i].code, 1'b1);
      wait_adv(1, 60, "tbl_adv");
      chk("tbl_eyes", c_eyes, tbl[i].eyes);
      chk("tbl_tail", c_tail, tbl[i].tail);
      chk("tbl_legs", c_legs, tbl[i].legs);
      chk("tbl_buzz", c_buzz, tbl[i].buzz);
      chk("tbl_cur_step", int'(cur_step), int'(tbl[i].code));
    end

    // glitch filter: 1 -> 3 (one cycle) -> 1
    do_reset(3'd1, 1'b1);
    tick(); step = 3'd3; tick(); step = 3'd1;
    wait_adv(1, 60, "glitch_adv");
    chk("glitch_legs", c_legs, 0);
    chk("glitch_tail", c_tail, AC);
    chk("glitch_cur_step", int'(cur_step), 1);

    // timeout: step stuck at 2 after adv, then counter finally moves to 3
    do_reset(3'd2, 1'b1);
    wait_adv(1, 60, "to_adv1");
    t1 = cyc; terr = -1;
    for (int k = 0; k < 60 && n_adv < 2; k++) begin
      tick();
      if (err && terr < 0) terr = cyc;
    end
    t2 = cyc;
    chk("to_adv2_seen", n_adv, 2);
    chk("to_adv_gap", t2 - t1, WM);
    chk("to_err_time", terr, t2 - 1);
    step = 3'd3; clr_cnt();
    wait_adv(1, 60, "to_recover_adv");
    chk("to_recover_legs", c_legs, AC);
    chk("to_recover_cur", int'(cur_step), 3);
    chk("to_err_sticky", int'(err), 1);

    // illegal code 6 held
    do_reset(3'd6, 1'b1);
    repeat (10) tick();
    chk("ill_err", int'(err), 1);
    chk("ill_busy", int'(busy), 1);
    chk("ill_actuators", c_eyes + c_tail + c_legs + c_buzz, 0);
    chk("ill_no_adv", n_adv, 0);
    chk("ill_cur_step", int'(cur_step), 6);
    en = 1'b0; tick();
    chk("ill_en_err", int'(err), 0);
    chk("ill_en_busy", int'(busy), 0);
    chk("ill_en_cur", int'(cur_step), 6);

    // buzzer waveform across the RUN window
    do_reset(3'd2, 1'b1);
    repeat (2 + SC) tick();
    for (int k = 0; k < AC; k++) begin
      tick();
      chk("buzz_wave", int'(buzzer), (k / TD) % 2);
    end

    // en low mid-RUN
    do_reset(3'd4, 1'b1);
    repeat (2 + SC + 3) tick();
    chk("enlow_pre_eyes", int'(eyes_led && tail_motor), 1);
    en = 1'b0; tick();
    chk("enlow_outputs", int'({adv, eyes_led, tail_motor, legs_motor, buzzer, busy}), 0);
    chk("enlow_cur_step", int'(cur_step), 4);

    // async reset mid-action, no clock edge involved
    do_reset(3'd3, 1'b1);
    repeat (2 + SC + 2) tick();
    chk("arst_pre_legs", int'(legs_motor), 1);
    #2 rst_n = 1'b0; #1;
    chk("arst_outputs", int'({adv, eyes_led, tail_motor, legs_motor, buzzer, busy, cur_step, err}), 0);

    // randomized closed loop against the counter model
    do_reset(3'd0, 1'b1);
    pend.delete(); done = 0; exp_code = 0;
    for (int k = 0; k < 3000 && done < 18; k++) begin
      tick();
      if (pend.size() > 0) step = pend.pop_front();
      if (adv) begin
        chk("loop_cur_step", int'(cur_step), exp_code);
        chk("loop_eyes", c_eyes, exp_cnt(exp_code, 0));
        chk("loop_tail", c_tail, exp_cnt(exp_code, 1));
        chk("loop_legs", c_legs, exp_cnt(exp_code, 2));
        chk("loop_buzz", c_buzz, exp_cnt(exp_code, 3));
        chk("loop_err", int'(err), 0);
        counter_advance(exp_code);
        exp_code = (exp_code + 1) % 6;
        done++;
        clr_cnt();
      end
    end
    chk("loop_actions", done, 18);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
